rgb_breath_scheduler: RTL

//  Sequencer for the RGB PWM LED datapath. Steps a 6-entry colour playlist and a breathing

---
 rtl/rgb_led_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 43 ++++
 rtl/rgb_breath_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - colour playlist constants and scheduler state encoding
package rgb_led_pkg;

    localparam logic [23:0] COL_RED    = 24'hdc143c;
    localparam logic [23:0] COL_ORANGE = 24'hff4500;
    localparam logic [23:0] COL_YELLOW = 24'hffd700;
    localparam logic [23:0] COL_BLUE   = 24'h1e90ff;
    localparam logic [23:0] COL_INDIGO = 24'h0000cd;
    localparam logic [23:0] COL_PURPLE = 24'h9400d3;
    localparam logic [23:0] COL_WHITE  = 24'hffffff;

    localparam int NCOLOUR = 6;

    typedef enum logic [1:0] {
        S_UP   = 2'd0,
        S_DOWN = 2'd1,
        S_ADV  = 2'd2
    } sched_state_t;

    function automatic logic [23:0] colour_lookup(input logic [2:0] idx);
        case (idx)
            3'd0:    colour_lookup = COL_RED;
            3'd1:    colour_lookup = COL_ORANGE;
            3'd2:    colour_lookup = COL_YELLOW;
            3'd3:    colour_lookup = COL_BLUE;
            3'd4:    colour_lookup = COL_INDIGO;
            3'd5:    colour_lookup = COL_PURPLE;
            default: colour_lookup = COL_RED;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus stable-level debouncer
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic deb,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            // any sample matching the current level restarts the stability count
            if (sync2 != deb) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    deb  <= sync2;
                    rise <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rgb_breath_scheduler.sv
// rtl/rgb_breath_scheduler.sv - colour playlist and breathing ramp sequencer feeding the PWM engine
module rgb_breath_scheduler
    import rgb_led_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int STEPS      = 1000,
    parameter int STEP       = 100,
    parameter int BRIGHT_W   = 17,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn,
    output logic [23:0]         cfg_colour,
    output logic [BRIGHT_W-1:0] cfg_bright,
    output logic                cfg_valid,
    input  logic                cfg_ready,
    output logic [2:0]          colour_idx,
    output logic                paused
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int RW = $clog2(STEPS + 1);
    localparam logic [BRIGHT_W-1:0] BMAX  = BRIGHT_W'(STEP * STEPS);
    localparam logic [BRIGHT_W-1:0] BSTEP = BRIGHT_W'(STEP);

    sched_state_t        state;
    logic [TW-1:0]       tick_cnt;
    logic [RW-1:0]       ramp_cnt;
    logic [BRIGHT_W-1:0] bright;
    logic [BRIGHT_W-1:0] bright_q;
    logic [2:0]          idx;
    logic [23:0]         eff_q;
    logic                dirty;
    logic                deb;
    logic                deb_rise;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .deb  (deb),
        .rise (deb_rise)
    );

    logic        tick;
    logic        step;
    logic        running;
    logic [23:0] eff_colour;
    logic        pending;
    logic        load;

    // a button edge wins over a coincident tick: the tick is dropped
    assign tick       = !paused && (tick_cnt == TW'(TICK_DIV - 1));
    assign step       = tick && !deb_rise;
    assign running    = !paused && !deb_rise;
    assign eff_colour = deb ? COL_WHITE : colour_lookup(idx);
    assign pending    = dirty || (eff_colour != eff_q) || (bright != bright_q);
    assign load       = pending && (!cfg_valid || cfg_ready);
    assign colour_idx = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_UP;
            ramp_cnt <= '0;
            bright   <= '0;
            idx      <= 3'd0;
        end else begin
            case (state)
                S_UP: if (step) begin
                    bright <= (bright >= BMAX - BSTEP) ? BMAX : bright + BSTEP;
                    if (ramp_cnt == RW'(STEPS - 1)) begin
                        ramp_cnt <= '0;
                        state    <= S_DOWN;
                    end else begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                    end
                end
                S_DOWN: if (step) begin
                    bright <= (bright <= BSTEP) ? '0 : bright - BSTEP;
                    if (ramp_cnt == RW'(STEPS - 1)) begin
                        ramp_cnt <= '0;
                        state    <= S_ADV;
                    end else begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                    end
                end
                S_ADV: if (running) begin
                    idx   <= (idx == 3'(NCOLOUR - 1)) ? 3'd0 : idx + 3'd1;
                    state <= S_UP;
                end
                default: begin
                    state    <= S_UP;
                    ramp_cnt <= '0;
                    bright   <= '0;
                    idx      <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            paused     <= 1'b0;
            dirty      <= 1'b1;
            eff_q      <= COL_WHITE;
            bright_q   <= '0;
            cfg_colour <= COL_WHITE;
            cfg_bright <= '0;
            cfg_valid  <= 1'b0;
        end else begin
            if (!paused)
                tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
            if (deb_rise)
                paused <= !paused;
            eff_q    <= eff_colour;
            bright_q <= bright;
            dirty    <= pending && !load;
            // changes that arrive while the channel is stalled coalesce into one update
            if (load) begin
                cfg_colour <= eff_colour;
                cfg_bright <= bright;
                cfg_valid  <= 1'b1;
            end else if (cfg_valid && cfg_ready) begin
                cfg_valid <= 1'b0;
            end
        end
    end

endmodule
